// File: rtl/series_pkg.sv
// Shared encodings for the series accumulator engine.
// Build option: SERIES_SAT_EN selects saturating accumulation.
package series_pkg;

  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_SQR   = 2'd1;
  localparam logic [1:0] MODE_GEOM  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/series_sum_engine_if.sv
// Host-facing Start/Busy/Done bundle of the series engine.
// Master is the host FSM, slave is the engine.
interface series_sum_engine_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH
);

  logic             Start;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] N;
  logic             Busy;
  logic             Done;
  logic [ACC_W-1:0] Result;
  logic             Ovf;

  modport master (
    output Start, Mode, A, D, N,
    input  Busy, Done, Result, Ovf
  );

  modport slave (
    input  Start, Mode, A, D, N,
    output Busy, Done, Result, Ovf
  );

endinterface

// File: rtl/series_term_unit.sv
// Combinational term step: contribution, next term and
// overflow flags for one series iteration.
module series_term_unit
  import series_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic [1:0]       mode,
  input  logic [ACC_W-1:0] term,
  input  logic [WIDTH-1:0] d,
  output logic [ACC_W-1:0] contrib,
  output logic [ACC_W-1:0] next_term,
  output logic             ovf
);

  localparam int PW = 2 * ACC_W;

  logic [PW-1:0]  sq;
  logic [PW-1:0]  pr;
  logic [ACC_W:0] add;

  always_comb begin
    sq  = PW'(term) * PW'(term);
    pr  = PW'(term) * PW'(d);
    add = (ACC_W+1)'(term) + (ACC_W+1)'(d);
  end

  // Reserved mode falls through to the arithmetic default.
  always_comb begin
    contrib   = term;
    next_term = add[ACC_W-1:0];
    ovf       = add[ACC_W];
    unique case (1'b1)
      (mode == MODE_SQR): begin
        contrib   = sq[ACC_W-1:0];
        next_term = add[ACC_W-1:0];
        ovf       = (|sq[PW-1:ACC_W]) | add[ACC_W];
      end
      (mode == MODE_GEOM): begin
        contrib   = term;
        next_term = pr[ACC_W-1:0];
        ovf       = |pr[PW-1:ACC_W];
      end
      default: begin
        contrib   = term;
        next_term = add[ACC_W-1:0];
        ovf       = add[ACC_W];
      end
    endcase
  end

endmodule

// File: rtl/series_sum_engine.sv
// Series accumulator: FSM, counter, accumulator, outputs.
// Build option: SERIES_SAT_EN saturates acc on overflow.
module series_sum_engine
  import series_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic                Clk,
  input  logic                Rst_n,
  series_sum_engine_if.slave  bus
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] term_q, term_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] contrib;
  logic [ACC_W-1:0] next_term;
  logic             tu_ovf;
  logic [ACC_W:0]   acc_sum;
  logic             ovf_now;

  series_term_unit #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_term (
    .mode      (mode_q),
    .term      (term_q),
    .d         (d_q),
    .contrib   (contrib),
    .next_term (next_term),
    .ovf       (tu_ovf)
  );

  always_comb begin
    acc_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(contrib);
    ovf_now = tu_ovf | acc_sum[ACC_W];
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    d_d      = d_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_LOAD;
          mode_d  = bus.Mode;
          a_d     = bus.A;
          d_d     = bus.D;
          n_d     = bus.N;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        term_d = ACC_W'(a_q);
        acc_d  = '0;
        cnt_d  = '0;
        if (n_q == '0) begin
          state_d  = S_DONE;
          result_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
`ifdef SERIES_SAT_EN
        // Once flagged, acc is pinned at all-ones.
        acc_d = (ovf_q | ovf_now) ? '1 : acc_sum[ACC_W-1:0];
`else
        acc_d = acc_sum[ACC_W-1:0];
`endif
        ovf_d  = ovf_q | ovf_now;
        term_d = next_term;
        cnt_d  = cnt_q + WIDTH'(1);
        if (cnt_q == n_q - WIDTH'(1)) begin
          state_d  = S_DONE;
          result_d = acc_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      a_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      d_q      <= d_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.Busy   = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.Done   = (state_q == S_DONE);
  assign bus.Result = result_q;
  assign bus.Ovf    = ovf_q;

endmodule
